// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fulladder.sv
// Single-bit combinational full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per clock, LSB first,
// through a single full adder and recirculates its carry.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;

  fulladder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          // Last bit: publish the completed sum including the bit computed now.
          if (cnt == LAST) begin
            sum_out   <= {fa_s, sum_sh[WIDTH-1:1]};
            carry_out <= fa_c;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         ready, busy, carry_out, done;
  logic [W-1:0] sum_out;

  int total = 0;
  int bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .ready     (ready),
    .busy      (busy),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after ready returns.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic ec, input string nm);
    int n;
    logic seen;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({nm, " busy"}, {30'd0, busy, ready}, 32'd2);
    n = 0;
    seen = done;
    while (!seen && n < W + 4) begin
      @(negedge clk);
      n++;
      seen = done;
    end
    check({nm, " latency"}, n, W);
    if (seen) begin
      check({nm, " sum"}, {23'd0, carry_out, sum_out}, {23'd0, ec, es});
      check({nm, " flags_done"}, {30'd0, busy, ready}, 32'd0);
      @(negedge clk);
      check({nm, " pulse"}, {30'd0, done, ready}, 32'd1);
    end
  endtask

  initial begin
    int ndone;
    int t;
    int t1;
    int t2;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic c1;
    logic c2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   rsum;

    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[7] = '{8'h01, 8'h02, 8'h03, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {29'd0, ready, busy, done}, 32'd4);
    check("reset_data", {23'd0, carry_out, sum_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

    // Start pulsed during RUN must not launch a second addition.
    start = 1'b1; a_in = 8'h10; b_in = 8'h20;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    s1 = '0;
    for (int i = 0; i < W + 12; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; a_in = 8'hAA; b_in = 8'h55; end
      if (i == 4) start = 1'b0;
      if (done) begin ndone++; s1 = sum_out; end
    end
    check("ignore_count", ndone, 1);
    check("ignore_sum", {24'd0, s1}, 32'h30);

    // Reset in the middle of RUN aborts with no done.
    start = 1'b1; a_in = 8'h80; b_in = 8'h80;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {29'd0, ready, busy, done}, 32'd4);
    check("abort_data", {23'd0, carry_out, sum_out}, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);

    // Start held high: second accept uses the operands changed after the first.
    start = 1'b1; a_in = 8'h5A; b_in = 8'h3C;
    @(posedge clk);
    #1 a_in = 8'h01; b_in = 8'h02;
    ndone = 0; t1 = 0; t2 = 0; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    for (t = 0; t < 4 * W; t++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin t1 = t; s1 = sum_out; c1 = carry_out; end
        if (ndone == 2) begin t2 = t; s2 = sum_out; c2 = carry_out; end
      end
      if (ndone == 1 && busy) start = 1'b0;
    end
    start = 1'b0;
    check("b2b_count", ndone, 2);
    check("b2b_first", {23'd0, c1, s1}, 32'h096);
    check("b2b_second", {23'd0, c2, s2}, 32'h003);
    check("b2b_spacing", t2 - t1, W + 2);

    while (!ready) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rsum = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, rsum[W-1:0], rsum[W], "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around the existing single-bit `fulladder` cell.
- Loads two operands on a start handshake and feeds the full adder one bit per clock, LSB first.
- Recirculates the full adder's c_out through a carry register, collects sum bits in a shift register, and reports sum plus final carry with a done pulse.
- This is the sequential stage that drives and consumes the combinational full adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- a_in  input  WIDTH  operand A; captured on the accepted start.
- b_in  input  WIDTH  operand B; captured on the accepted start.
- ready  output  1  high in IDLE; start is accepted only while high.
- busy  output  1  high in RUN.
- sum_out  output  WIDTH  registered sum, valid from done until the next accepted start.
- carry_out  output  1  registered final carry, same validity as sum_out.
- done  output  1  one-cycle pulse marking result valid.

Behaviour:
- Reset: one clock, synchronous, active-low; the polarity and synchronicity are fixed.
  - Any clk edge with rst_n=0 returns the block to IDLE.
  - It also clears the A/B/sum shift registers, the carry register, the counter, sum_out, carry_out and done.
  - Resulting outputs: ready=1, busy=0, done=0, sum_out=0, carry_out=0.
  - Reset overrides start. Reset during RUN or DONE aborts the operation, and no done is issued.
- States:
  - IDLE: ready=1. start=1 at an edge loads a_sh<=a_in, b_sh<=b_in, clears carry and counter, and moves to RUN.
  - RUN: busy=1. Each edge:
    - the full adder sees a=a_sh[0], b=b_sh[0], c_in=carry;
    - a_sh and b_sh shift right (zero fill);
    - s shifts into sum_sh MSB, with sum_sh shifting right;
    - carry<=c_out;
    - counter increments.
    - At the edge where counter==WIDTH-1, the block goes to DONE and loads sum_out<=final sum_sh, carry_out<=c_out, done<=1.
  - DONE: done=1 for exactly this cycle; ready=0, busy=0; the next edge always moves to IDLE.
- Latency:
  - Start accepted at edge k gives done high in the cycle after edge k+WIDTH.
  - ready is high again after edge k+WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start in RUN or DONE is ignored, with no queuing. start held continuously is re-accepted at the first IDLE edge.
- a_in/b_in changes after acceptance have no effect on the running addition.
- Arithmetic: {carry_out, sum_out} = a_in + b_in, modulo 2^(WIDTH+1), unsigned.
- Counter: exact 0..WIDTH-1 with no wrap beyond. For WIDTH a power of two the counter naturally wraps to 0 on exit; this is harmless because IDLE reloads it.
- sum_out/carry_out hold their last value through IDLE. They update only at the RUN→DONE edge and never glitch during RUN.
- No X on any output after the first reset edge.

Decomposition:
- Shared package `adder_pkg`:
  - state enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2};
  - DEFAULT_WIDTH=8.
- Sub-module: one `fulladder` instance (ports a, b, c_in, s, c_out), used unmodified.
- Everything else (FSM, shift registers, carry register, counter) lives in serial_adder.

Test Plan (WIDTH=8):
- Basic add: reset, then start with a_in=8'h5A, b_in=8'h3C → done after 8 cycles; sum_out=8'h96, carry_out=0; ready=1 two cycles after the start edge + 8.
- Carry ripple: a_in=8'hFF, b_in=8'h01 → sum_out=8'h00, carry_out=1. Then a_in=8'hFF, b_in=8'hFF → sum_out=8'hFE, carry_out=1.
- Busy ignore: start a=8'h10, b=8'h20; pulse start with a=8'hAA, b=8'h55 during RUN → exactly one done, sum_out=8'h30; the second request is not executed.
- Reset mid-op: start a=8'h80, b=8'h80; drop rst_n at RUN cycle 4 → next edge gives ready=1, busy=0, sum_out=0, carry_out=0; done never pulses.
- Back-to-back: start held high with a/b changed to 8'h01/8'h02 after the first accept → results 8'h96 then 8'h03; done pulses are exactly WIDTH+2=10 cycles apart.
- Random sweep: 1000 random operand pairs → {carry_out, sum_out} == a_in+b_in every time; done is always a single-cycle pulse.
